face_scheduler: RTL and testbench

- Sequences the triangle shader across a frame's face list.
- Reads six 16-bit vertex words per face from the face RAM (v1x, v1y, v2x, v2y, v3x, v3y) and registers them onto the shader's vertex inputs.
- Pulses shader start, waits for shader done, then moves to the next face; signals frame_done after the last face.
- Sits between the frame/host control logic and the shader; owns the shader's start/v*/done handshake.

---
 rtl/face_scheduler.sv | 151 +++++++++++++++
 tb/tb_face_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/face_scheduler.sv
// Face scheduler: walks a frame's face list, fetches six vertex words per face
// from the face RAM, culls degenerate triangles and runs the shader handshake.
module face_scheduler #(
    parameter int FACE_W       = 10,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 1048576
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic [FACE_W-1:0] num_faces,
    output logic              mem_rd,
    output logic [FACE_W+2:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic              shader_start,
    output logic [15:0]       v1x,
    output logic [15:0]       v1y,
    output logic [15:0]       v2x,
    output logic [15:0]       v2y,
    output logic [15:0]       v3x,
    output logic [15:0]       v3y,
    input  logic              shader_done,
    output logic              busy,
    output logic              frame_done,
    output logic [FACE_W-1:0] faces_drawn,
    output logic [FACE_W-1:0] faces_skipped,
    output logic              timeout_err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] NEXT  = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(START_CYCLES - 1);

    logic [2:0]        state;
    logic [2:0]        state_d;
    logic [2:0]        fetch_cnt;
    logic [SC_W-1:0]   start_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [FACE_W-1:0] face_idx;
    logic [FACE_W-1:0] face_total;
    logic [FACE_W-1:0] face_next;
    logic              same_12;
    logic              same_23;
    logic              same_13;
    logic              degenerate;

    // Control outputs decode straight from state, so an async reset clears them at once.
    assign mem_rd       = (state == FETCH) && (fetch_cnt < 3'd6);
    assign mem_addr     = mem_rd ? {face_idx, fetch_cnt} : '0;
    assign shader_start = (state == START);
    assign busy         = (state != IDLE) && (state != DONE);
    assign frame_done   = (state == DONE);

    assign face_next  = face_idx + FACE_W'(1);
    assign same_12    = (v1x == v2x) && (v1y == v2y);
    assign same_23    = (v2x == v3x) && (v2y == v3y);
    assign same_13    = (v1x == v3x) && (v1y == v3y);
    assign degenerate = same_12 || same_23 || same_13;

    always_comb begin
        // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state;
        case (state)
            IDLE:    if (frame_start) state_d = (num_faces == '0) ? DONE : FETCH;
            FETCH:   if (fetch_cnt == 3'd6) state_d = CHECK;
            CHECK:   state_d = degenerate ? NEXT : START;
            START:   if (start_cnt == SC_LAST) state_d = WAIT;
            WAIT:    if (shader_done || (to_cnt == TO_LAST)) state_d = NEXT;
            NEXT:    state_d = (face_next == face_total) ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            fetch_cnt     <= '0;
            start_cnt     <= '0;
            to_cnt        <= '0;
            face_idx      <= '0;
            face_total    <= '0;
            faces_drawn   <= '0;
            faces_skipped <= '0;
            timeout_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            state     <= state_d;
            fetch_cnt <= (state == FETCH) ? fetch_cnt + 3'd1 : 3'd0;
            start_cnt <= (state == START) ? start_cnt + SC_W'(1) : '0;
            to_cnt    <= (state == WAIT) ? to_cnt + TO_W'(1) : '0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        face_total    <= num_faces;
                        face_idx      <= '0;
                        faces_drawn   <= '0;
                        faces_skipped <= '0;
                        timeout_err   <= 1'b0;
                    end
                end
                CHECK: if (degenerate) faces_skipped <= faces_skipped + FACE_W'(1);
                WAIT: begin
                    // A done arriving on the last timeout cycle still counts as drawn.
                    if (shader_done) begin
                        faces_drawn <= faces_drawn + FACE_W'(1);
                    end else if (to_cnt == TO_LAST) begin
                        timeout_err   <= 1'b1;
                        faces_skipped <= faces_skipped + FACE_W'(1);
                    end
                end
                NEXT:    face_idx <= face_next;
                default: ;
            endcase
        end
    end

    // Read data lags the strobe by one cycle, so word k lands while fetch_cnt == k+1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: these six flops drive the shader directly and must read zero after reset;
            // a real RAM array would be left unreset.
            v1x <= '0;
            v1y <= '0;
            v2x <= '0;
            v2y <= '0;
            v3x <= '0;
            v3y <= '0;
        end else if (state == FETCH) begin
            case (fetch_cnt)
                3'd1:    v1x <= mem_rdata;
                3'd2:    v1y <= mem_rdata;
                3'd3:    v2x <= mem_rdata;
                3'd4:    v2y <= mem_rdata;
                3'd5:    v3x <= mem_rdata;
                3'd6:    v3y <= mem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_face_scheduler.sv
// Directed bench for face_scheduler: RAM and shader models plus queue scoreboards
// for read addresses, vertex sets at shader start, and per-frame results.
module tb_face_scheduler;

    localparam int FACE_W  = 10;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              frame_start;
    logic [FACE_W-1:0] num_faces;
    logic              mem_rd;
    logic [FACE_W+2:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic              shader_start;
    logic [15:0]       v1x, v1y, v2x, v2y, v3x, v3y;
    logic              shader_done;
    logic              busy;
    logic              frame_done;
    logic [FACE_W-1:0] faces_drawn;
    logic [FACE_W-1:0] faces_skipped;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;
    int shader_delay = 0;
    int start_pulses = 0;
    int done_pulses = 0;
    int rd_count = 0;

    logic [15:0] ram [0:8191];
    logic [12:0] addr_q [$];
    logic [95:0] vtx_q [$];
    logic [20:0] res_q [$];

    face_scheduler #(
        .FACE_W      (FACE_W),
        .START_CYCLES(2),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .num_faces    (num_faces),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .shader_start (shader_start),
        .v1x          (v1x),
        .v1y          (v1y),
        .v2x          (v2x),
        .v2y          (v2y),
        .v3x          (v3x),
        .v3y          (v3y),
        .shader_done  (shader_done),
        .busy         (busy),
        .frame_done   (frame_done),
        .faces_drawn  (faces_drawn),
        .faces_skipped(faces_skipped),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_face(input int idx, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3,
                            input logic [15:0] w4, input logic [15:0] w5);
        ram[13'(idx * 8 + 0)] = w0;
        ram[13'(idx * 8 + 1)] = w1;
        ram[13'(idx * 8 + 2)] = w2;
        ram[13'(idx * 8 + 3)] = w3;
        ram[13'(idx * 8 + 4)] = w4;
        ram[13'(idx * 8 + 5)] = w5;
    endtask

    task automatic push_addrs(input int idx);
        for (int k = 0; k < 6; k++) addr_q.push_back(13'(idx * 8 + k));
    endtask

    task automatic push_vtx(input int idx);
        vtx_q.push_back({ram[13'(idx * 8 + 0)], ram[13'(idx * 8 + 1)], ram[13'(idx * 8 + 2)],
                         ram[13'(idx * 8 + 3)], ram[13'(idx * 8 + 4)], ram[13'(idx * 8 + 5)]});
    endtask

    task automatic push_res(input int drawn, input int skipped, input logic err);
        res_q.push_back({10'(drawn), 10'(skipped), err});
    endtask

    task automatic start_frame(input int n);
        @(negedge clk);
        frame_start = 1'b1;
        num_faces   = 10'(n);
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_start(input logic level);
        int n;
        n = 0;
        while (shader_start !== level && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("wait_shader_start", 96'(shader_start), 96'(level));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("wait_frame_done", 96'(frame_done), 96'd1);
        @(negedge clk);
    endtask

    // RAM responder and output monitors, all sampled on the falling edge.
    initial begin : monitor
        logic        pend_rd;
        logic [12:0] pend_addr;
        logic        prev_start;
        int          start_len;
        logic [95:0] cur_vtx;
        pend_rd    = 1'b0;
        pend_addr  = '0;
        prev_start = 1'b0;
        start_len  = 0;
        cur_vtx    = '0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pend_rd    = 1'b0;
                prev_start = 1'b0;
                start_len  = 0;
            end else begin
                if (pend_rd) mem_rdata = ram[pend_addr];
                pend_rd   = mem_rd;
                pend_addr = mem_addr;
                if (mem_rd) begin
                    rd_count++;
                    if (addr_q.size() == 0) check("mem_rd_extra", 96'(mem_rd), 96'd0);
                    else check("mem_addr", 96'(mem_addr), 96'(addr_q.pop_front()));
                end
                if (shader_start && !prev_start) begin
                    start_pulses++;
                    if (vtx_q.size() == 0) check("shader_start_extra", 96'(shader_start), 96'd0);
                    else cur_vtx = vtx_q.pop_front();
                end
                if (shader_start) begin
                    start_len++;
                    check("vtx_hold", {v1x, v1y, v2x, v2y, v3x, v3y}, cur_vtx);
                end else if (prev_start) begin
                    check("start_len", 96'(start_len), 96'd2);
                    start_len = 0;
                end
                prev_start = shader_start;
                if (frame_done) begin
                    done_pulses++;
                    if (res_q.size() == 0) check("frame_done_extra", 96'(frame_done), 96'd0);
                    else check("frame_result", 96'({faces_drawn, faces_skipped, timeout_err, busy}),
                               96'({res_q.pop_front(), 1'b0}));
                end
            end
        end
    end

    // Shader: done pulses shader_delay cycles after the start rise; 0 means never.
    initial begin : shader_model
        logic seen;
        seen        = 1'b0;
        shader_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                seen = 1'b0;
            end else if (shader_start && !seen) begin
                seen = 1'b1;
                if (shader_delay > 0) begin
                    for (int i = 1; i < shader_delay && reset_n; i++) @(negedge clk);
                    if (reset_n) begin
                        shader_done = 1'b1;
                        @(negedge clk);
                        shader_done = 1'b0;
                    end
                end
            end else if (!shader_start) begin
                seen = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int cnt;
        int snap_start;
        int snap_rd;
        int snap_done;

        for (int i = 0; i < 8192; i++) ram[i] = '0;
        set_face(0, 16'h30A9, 16'h1AB2, 16'h315F, 16'h1B57, 16'h27FC, 16'h1B5F);
        set_face(1, 16'h0010, 16'h0020, 16'h0064, 16'h00C8, 16'h0064, 16'h00C8);
        set_face(2, 16'h0100, 16'h0200, 16'h0300, 16'h0050, 16'h0123, 16'h0456);

        reset_n     = 1'b0;
        frame_start = 1'b0;
        num_faces   = '0;
        repeat (3) @(negedge clk);
        check("rst_shader_start", 96'(shader_start), 96'd0);
        check("rst_busy", 96'(busy), 96'd0);
        check("rst_frame_done", 96'(frame_done), 96'd0);
        check("rst_mem_rd", 96'(mem_rd), 96'd0);
        check("rst_counters", 96'({faces_drawn, faces_skipped, timeout_err}), 96'd0);
        check("rst_vertices", {v1x, v1y, v2x, v2y, v3x, v3y}, 96'd0);
        reset_n = 1'b1;

        // One face, shader done after 50 cycles.
        shader_delay = 50;
        push_addrs(0);
        push_vtx(0);
        push_res(1, 0, 1'b0);
        start_frame(1);
        check("busy_after_accept", 96'(busy), 96'd1);
        wait_done();
        check("idle_after_frame", 96'(busy), 96'd0);

        // Empty frame: frame_done the cycle after accept, nothing fetched or started.
        snap_start = start_pulses;
        snap_rd    = rd_count;
        push_res(0, 0, 1'b0);
        start_frame(0);
        check("zero_frame_done", 96'(frame_done), 96'd1);
        check("zero_busy", 96'(busy), 96'd0);
        repeat (3) @(negedge clk);
        check("zero_no_reads", 96'(rd_count), 96'(snap_rd));
        check("zero_no_start", 96'(start_pulses), 96'(snap_start));

        // Three faces, middle one degenerate.
        shader_delay = 20;
        snap_start = start_pulses;
        push_addrs(0);
        push_addrs(1);
        push_addrs(2);
        push_vtx(0);
        push_vtx(2);
        push_res(2, 1, 1'b0);
        start_frame(3);
        wait_done();
        check("three_start_pulses", 96'(start_pulses), 96'(snap_start + 2));

        // Shader never answers: exactly TIMEOUT wait cycles before the error.
        shader_delay = 0;
        push_addrs(0);
        push_vtx(0);
        push_res(0, 1, 1'b1);
        start_frame(1);
        wait_start(1'b1);
        wait_start(1'b0);
        cnt = 0;
        while (timeout_err !== 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_cycles", 96'(cnt), 96'(TIMEOUT));
        wait_done();
        check("timeout_err_holds", 96'(timeout_err), 96'd1);

        // Done on the final timeout cycle wins; the error clears on accept.
        shader_delay = TIMEOUT + 2;
        push_addrs(0);
        push_vtx(0);
        push_res(1, 0, 1'b0);
        start_frame(1);
        check("err_cleared_on_accept", 96'(timeout_err), 96'd0);
        wait_done();

        // Done one cycle too late: timed out.
        shader_delay = TIMEOUT + 3;
        push_addrs(0);
        push_vtx(0);
        push_res(0, 1, 1'b1);
        start_frame(1);
        wait_done();

        // frame_start while busy is ignored.
        shader_delay = 30;
        push_addrs(0);
        push_vtx(0);
        push_res(1, 0, 1'b0);
        snap_done = done_pulses;
        start_frame(1);
        wait_start(1'b1);
        wait_start(1'b0);
        start_frame(5);
        check("busy_ignores_start", 96'(busy), 96'd1);
        wait_done();
        snap_rd = rd_count;
        repeat (100) @(negedge clk);
        check("single_frame_done", 96'(done_pulses), 96'(snap_done + 1));
        check("no_extra_reads", 96'(rd_count), 96'(snap_rd));
        check("idle_after_ignore", 96'(busy), 96'd0);

        // Reset while shader_start is high on face 2.
        shader_delay = 10;
        push_addrs(0);
        push_addrs(1);
        push_addrs(2);
        push_vtx(0);
        push_vtx(2);
        snap_done = done_pulses;
        start_frame(3);
        wait_start(1'b1);
        wait_start(1'b0);
        wait_start(1'b1);
        check("pre_reset_counts", 96'({faces_drawn, faces_skipped}), 96'({10'd1, 10'd1}));
        #1 reset_n = 1'b0;
        #1;
        check("async_shader_start", 96'(shader_start), 96'd0);
        check("async_busy", 96'(busy), 96'd0);
        check("async_counters", 96'({faces_drawn, faces_skipped, timeout_err}), 96'd0);
        check("async_vertices", {v1x, v1y, v2x, v2y, v3x, v3y}, 96'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("reset_no_frame_done", 96'(done_pulses), 96'(snap_done));

        push_addrs(0);
        push_vtx(0);
        push_res(1, 0, 1'b0);
        start_frame(1);
        wait_done();

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 96'(addr_q.size() + vtx_q.size() + res_q.size()), 96'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
